// File: rtl/drr_pkg.sv
// Shared types and constants for the DRR packet-size source.
//   gen_mode_t : size generation mode latched at the start of a run
//   q_state_t  : per-queue run state
//   POLY32     : toggle mask of the right-shifting 32-bit Galois LFSR
package drr_pkg;

  typedef enum logic [1:0] {GEN_FIXED, GEN_INCR, GEN_RAND} gen_mode_t;

  typedef enum logic [1:0] {Q_IDLE, Q_ACTIVE, Q_DONE} q_state_t;

  localparam logic [31:0] POLY32 = 32'h80200003;

endpackage

// File: rtl/drr_pkt_gen_if.sv
// Consume/size bus between the packet-size source (master) and the DRR
// scheduler (slave).
//   cng_addr : queue whose head packet is consumed
//   cng_val  : consume strobe
//   size     : head-of-line size per queue
//   size_val : per-queue size valid
// Handshake: size[q] is meaningful only while size_val[q] is 1. A consume is a
// single-cycle strobe (cng_val=1 with cng_addr=q) and is taken in that same
// cycle if and only if size_val[q] is 1; there is no back-pressure signal, so
// a strobe aimed at a queue without a valid size is simply discarded. The
// replacement size appears on the following cycle.
interface drr_pkt_gen_if #(
  parameter int PKT_QS_CNT = 4,
  parameter int SIZE_W     = 16
);
  localparam int AW = (PKT_QS_CNT > 1) ? $clog2(PKT_QS_CNT) : 1;

  logic [AW-1:0]                     cng_addr;
  logic                              cng_val;
  logic [PKT_QS_CNT-1:0][SIZE_W-1:0] size;
  logic [PKT_QS_CNT-1:0]             size_val;

  modport master (input cng_addr, input cng_val, output size, output size_val);
  modport slave  (output cng_addr, output cng_val, input size, input size_val);
endinterface

// File: rtl/drr_lfsr.sv
// 32-bit right-shifting Galois LFSR, free running, synchronous reset to SEED.
//   clk_i   : clock
//   rst_i   : synchronous reset, active-high
//   state_o : current LFSR state
module drr_lfsr
  import drr_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE12345
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Bit 0 shifts out; when it is 1 the polynomial mask is folded back in.
  assign state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? POLY32 : 32'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/drr_pkt_gen.sv
// Per-queue packet-size source feeding a DRR scheduler. Each queue holds one
// head-of-line size which is refilled when the scheduler consumes it. Sizes
// are fixed, incrementing or pseudo-random; a queue stops after PKT_LIMIT
// packets (0 = never).
//   clk_i       : clock
//   rst_i       : synchronous reset, active-high
//   start_i     : pulse, (re)starts a run on all queues
//   mode_i      : 0 fixed, 1 incr, 2 random, 3 treated as fixed; sampled at start_i
//   fixed_sz_i  : size for fixed mode; sampled at start_i
//   done_o      : every queue has reached DONE
//   dbg_state_o : per-queue FSM state (q_state_t encoding)
//   bus         : consume strobe in, head sizes/valids out
module drr_pkt_gen
  import drr_pkg::*;
#(
  parameter int          PKT_QS_CNT = 4,
  parameter int          SIZE_W     = 16,
  parameter int          MIN_SIZE   = 64,
  parameter int          MAX_SIZE   = 1500,
  parameter int          INCR_STEP  = 64,
  parameter int          PKT_LIMIT  = 16,
  parameter logic [31:0] SEED       = 32'hACE12345
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic [SIZE_W-1:0]           fixed_sz_i,
  output logic                        done_o,
  output logic [PKT_QS_CNT-1:0][1:0]  dbg_state_o,
  drr_pkt_gen_if.master               bus
);

  localparam int AW    = (PKT_QS_CNT > 1) ? $clog2(PKT_QS_CNT) : 1;
  localparam int RANGE = MAX_SIZE - MIN_SIZE + 1;
  localparam int CNT_W = $clog2(PKT_LIMIT + 2);

  localparam logic [SIZE_W-1:0] MIN_C   = SIZE_W'(MIN_SIZE);
  localparam logic [SIZE_W-1:0] MAX_C   = SIZE_W'(MAX_SIZE);
  localparam logic [SIZE_W-1:0] RANGE_C = SIZE_W'(RANGE);
  localparam logic [SIZE_W-1:0] MASK_C  = SIZE_W'((1 << $clog2(RANGE)) - 1);
  localparam logic [SIZE_W:0]   STEP_C  = (SIZE_W + 1)'(INCR_STEP);
  localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(PKT_LIMIT);

  if (MIN_SIZE > MAX_SIZE || MAX_SIZE >= (1 << SIZE_W)) begin : g_bad_size
    $error("drr_pkt_gen: need MIN_SIZE <= MAX_SIZE < 2**SIZE_W");
  end
  if (SEED == 32'd0) begin : g_bad_seed
    $error("drr_pkt_gen: SEED must be non-zero");
  end

  // Maps LFSR bits into [MIN, MAX]. MASK < 2*RANGE, so a single conditional
  // subtract folds the masked value into range. The queue-dependent key keeps
  // queues loaded in the same cycle from getting identical sizes.
  function automatic logic [SIZE_W-1:0] rand_size(input logic [SIZE_W-1:0] lfsr_lo,
                                                  input int unsigned q);
    logic [SIZE_W-1:0] c;
    c = (lfsr_lo ^ SIZE_W'(q * 32'h9E37)) & MASK_C;
    if (c >= RANGE_C) c = c - RANGE_C;
    return MIN_C + c;
  endfunction

  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] v);
    if (v < MIN_C)      return MIN_C;
    else if (v > MAX_C) return MAX_C;
    else                return v;
  endfunction

  logic [31:0] lfsr;
  logic        unused_lfsr_hi;

  drr_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .state_o (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[31:SIZE_W];

  // Run-wide settings, captured on start_i.
  gen_mode_t         mode_q, mode_d;
  logic [SIZE_W-1:0] fixed_q, fixed_d;

  always_comb begin
    mode_d = GEN_FIXED;
    case (mode_i)
      2'd1:    mode_d = GEN_INCR;
      2'd2:    mode_d = GEN_RAND;
      default: mode_d = GEN_FIXED;
    endcase
    fixed_d = clamp_size(fixed_sz_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= GEN_FIXED;
      fixed_q <= MIN_C;
    end else if (start_i) begin
      mode_q  <= mode_d;
      fixed_q <= fixed_d;
    end
  end

  logic [PKT_QS_CNT-1:0] is_done;

  for (genvar g = 0; g < PKT_QS_CNT; g++) begin : g_q
    q_state_t          state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [SIZE_W-1:0] size_q;
    logic              val_q;
    logic [SIZE_W-1:0] first_sz;
    logic [SIZE_W-1:0] next_sz;
    logic [SIZE_W:0]   incr_sum;
    logic              hit;

    // Out-of-range addresses match no queue and are dropped here; val_q is
    // only set while ACTIVE, so IDLE/DONE queues ignore consumes too.
    assign hit     = bus.cng_val && (bus.cng_addr == AW'(g)) && val_q;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
      // First size of a run uses the mode being latched this cycle.
      first_sz = fixed_d;
      case (mode_d)
        GEN_INCR: first_sz = MIN_C;
        GEN_RAND: first_sz = rand_size(lfsr[SIZE_W-1:0], g);
        default:  first_sz = fixed_d;
      endcase
      // Refill size uses the latched mode; the add is one bit wider.
      incr_sum = {1'b0, size_q} + STEP_C;
      next_sz  = fixed_q;
      case (mode_q)
        GEN_INCR: next_sz = (incr_sum > {1'b0, MAX_C}) ? MIN_C : incr_sum[SIZE_W-1:0];
        GEN_RAND: next_sz = rand_size(lfsr[SIZE_W-1:0], g);
        default:  next_sz = fixed_q;
      endcase
    end

    // start_i has priority, so a simultaneous consume is neither applied nor counted.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= Q_IDLE;
        cnt_q   <= '0;
        size_q  <= '0;
        val_q   <= 1'b0;
      end else if (start_i) begin
        state_q <= Q_ACTIVE;
        cnt_q   <= '0;
        size_q  <= first_sz;
        val_q   <= 1'b1;
      end else if (hit) begin
        cnt_q <= cnt_inc;
        if (PKT_LIMIT != 0 && cnt_inc == LIMIT_C) begin
          // Queue drained: size keeps its last value, valid drops.
          state_q <= Q_DONE;
          val_q   <= 1'b0;
        end else begin
          size_q <= next_sz;
        end
      end
    end

    assign bus.size[g]     = size_q;
    assign bus.size_val[g] = val_q;
    assign dbg_state_o[g]  = state_q;
    assign is_done[g]      = (state_q == Q_DONE);
  end

  assign done_o = &is_done;

endmodule

// File: tb/tb_drr_pkt_gen.sv
// Directed bench for drr_pkt_gen. Two instances share one stimulus stream:
//   dut_a : INCR_STEP=512, PKT_LIMIT=0 (unlimited) - fixed/incr/random sizes
//   dut_c : INCR_STEP=64,  PKT_LIMIT=3            - drain, done, counters
module tb_drr_pkt_gen;

  localparam int NQ    = 4;
  localparam int SW    = 16;
  localparam int NRAND = 2000;

  // Clock / reset and shared stimulus
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic [1:0]    mode     = 2'd0;
  logic [SW-1:0] fixed_sz = '0;
  logic [1:0]    cng_addr = '0;
  logic          cng_val  = 1'b0;

  logic             done_a, done_c;
  logic [NQ-1:0][1:0] dbg_a, dbg_c;

  drr_pkt_gen_if #(.PKT_QS_CNT(NQ), .SIZE_W(SW)) if_a ();
  drr_pkt_gen_if #(.PKT_QS_CNT(NQ), .SIZE_W(SW)) if_c ();

  assign if_a.cng_addr = cng_addr;
  assign if_a.cng_val  = cng_val;
  assign if_c.cng_addr = cng_addr;
  assign if_c.cng_val  = cng_val;

  drr_pkt_gen #(.INCR_STEP(512), .PKT_LIMIT(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .fixed_sz_i(fixed_sz),
    .done_o(done_a), .dbg_state_o(dbg_a), .bus(if_a)
  );

  drr_pkt_gen #(.INCR_STEP(64), .PKT_LIMIT(3)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .fixed_sz_i(fixed_sz),
    .done_o(done_c), .dbg_state_o(dbg_c), .bus(if_c)
  );

  // Reference LFSR: right-shifting Galois, mask 0x80200003, reset to seed.
  logic [31:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 32'hACE12345;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
  end

  // Random size for MIN=64, MAX=1500: RANGE=1437, MASK=0x7FF.
  function automatic logic [SW-1:0] exp_rand(input logic [31:0] l, input int q);
    logic [SW-1:0] k, c;
    k = 16'(q * 16'h9E37);
    c = (l[15:0] ^ k) & 16'h07FF;
    if (c >= 16'd1437) c = c - 16'd1437;
    return 16'd64 + c;
  endfunction

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];
  logic [1:0]    addr_tab[NRAND];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [SW-1:0] fs);
    mode = m; fixed_sz = fs; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic consume(input logic [1:0] q);
    cng_addr = q; cng_val = 1'b1;
    tick();
    cng_val = 1'b0;
  endtask

  task automatic run_rand(input bit record);
    logic [31:0]   snap;
    logic [SW-1:0] sz;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 2'd2; start = 1'b1;
    snap = m_lfsr;
    tick();
    start = 1'b0;
    for (int q = 0; q < NQ; q++) chk("rand_first", 64'(if_a.size[q]), 64'(exp_rand(snap, q)));
    for (int i = 0; i < NRAND; i++) begin
      cng_addr = addr_tab[i]; cng_val = 1'b1;
      snap = m_lfsr;
      tick();
      sz = if_a.size[addr_tab[i]];
      chk("rand_value", 64'(sz), 64'(exp_rand(snap, int'(addr_tab[i]))));
      chk("rand_range", 64'(sz >= 16'd64 && sz <= 16'd1500), 64'd1);
      if (record) exp_q.push_back(sz);
      else if (exp_q.size() > 0) chk("rand_rerun", 64'(sz), 64'(exp_q.pop_front()));
      else chk("rand_rerun_len", 64'd0, 64'd1);
    end
    cng_val = 1'b0;
    chk("rand_val", 64'(if_a.size_val), 64'hF);
  endtask

  initial begin
    // 1: reset held 3 cycles, then a fixed-size run
    repeat (3) tick();
    chk("rst_size_a", 64'(if_a.size), 64'h0);
    chk("rst_val_a", 64'(if_a.size_val), 64'h0);
    chk("rst_done_a", 64'(done_a), 64'h0);
    chk("rst_dbg_c", 64'(dbg_c), 64'h0);
    rst = 1'b0;
    do_start(2'd0, 16'd100);
    chk("fix100_size", 64'(if_a.size), 64'h0064_0064_0064_0064);
    chk("fix100_val", 64'(if_a.size_val), 64'hF);
    chk("fix100_dbg", 64'(dbg_a), 64'h55);

    // 2: fixed clamping, reserved mode behaves as fixed
    do_start(2'd0, 16'd20);
    chk("fix_lo_clamp", 64'(if_a.size), 64'h0040_0040_0040_0040);
    do_start(2'd0, 16'd2000);
    chk("fix_hi_clamp", 64'(if_a.size), 64'h05DC_05DC_05DC_05DC);
    do_start(2'd3, 16'd300);
    chk("mode3_fixed", 64'(if_a.size), 64'h012C_012C_012C_012C);
    consume(2'd1);
    chk("fixed_refill", 64'(if_a.size), 64'h012C_012C_012C_012C);
    chk("fixed_refill_val", 64'(if_a.size_val), 64'hF);

    // 3: incrementing sizes on q2 (step 512 on dut_a, step 64 on dut_c)
    do_start(2'd1, 16'd0);
    chk("incr_first", 64'(if_a.size), 64'h0040_0040_0040_0040);
    consume(2'd2);
    chk("incr_1_a", 64'(if_a.size), 64'h0040_0240_0040_0040);
    chk("incr_1_c", 64'(if_c.size), 64'h0040_0080_0040_0040);
    consume(2'd2);
    chk("incr_2_a", 64'(if_a.size), 64'h0040_0440_0040_0040);
    consume(2'd2);
    chk("incr_wrap_a", 64'(if_a.size), 64'h0040_0040_0040_0040);
    chk("incr_done_c_size", 64'(if_c.size), 64'h0040_00C0_0040_0040);
    chk("incr_done_c_val", 64'(if_c.size_val), 64'hB);

    // 5: drain with PKT_LIMIT=3
    do_start(2'd0, 16'd100);
    consume(2'd0);
    chk("lim_1_val", 64'(if_c.size_val), 64'hF);
    consume(2'd0);
    chk("lim_2_val", 64'(if_c.size_val), 64'hF);
    consume(2'd0);
    chk("lim_3_val", 64'(if_c.size_val), 64'hE);
    chk("lim_3_size", 64'(if_c.size), 64'h0064_0064_0064_0064);
    consume(2'd0);
    chk("lim_4_ignored", 64'(if_c.size_val), 64'hE);
    chk("lim_4_state", 64'(dbg_c[0]), 64'd2);
    for (int q = 1; q < NQ; q++) repeat (3) consume(2'(q));
    chk("drain_done", 64'(done_c), 64'd1);
    chk("drain_val", 64'(if_c.size_val), 64'h0);
    chk("drain_done_a", 64'(done_a), 64'd0);
    do_start(2'd0, 16'd100);
    chk("restart_done", 64'(done_c), 64'd0);
    chk("restart_val", 64'(if_c.size_val), 64'hF);

    // 6: start and consume in the same cycle; counter must restart from 0
    mode = 2'd1; start = 1'b1; cng_addr = 2'd0; cng_val = 1'b1;
    tick();
    start = 1'b0; cng_val = 1'b0;
    chk("sc_size_c", 64'(if_c.size), 64'h0040_0040_0040_0040);
    chk("sc_size_a", 64'(if_a.size), 64'h0040_0040_0040_0040);
    consume(2'd0);
    consume(2'd0);
    chk("sc_cnt2_val", 64'(if_c.size_val), 64'hF);
    chk("sc_cnt2_size_c", 64'(if_c.size), 64'h0040_0040_0040_00C0);
    chk("sc_cnt2_size_a", 64'(if_a.size), 64'h0040_0040_0040_0440);
    consume(2'd0);
    chk("sc_cnt3_val", 64'(if_c.size_val), 64'hE);

    // rst mid-run returns everything to reset values
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_size_a", 64'(if_a.size), 64'h0);
    chk("midrst_val_c", 64'(if_c.size_val), 64'h0);
    chk("midrst_dbg_c", 64'(dbg_c), 64'h0);
    chk("midrst_done_c", 64'(done_c), 64'd0);

    // consume of an IDLE queue is ignored
    consume(2'd1);
    chk("idle_size_a", 64'(if_a.size), 64'h0);
    chk("idle_val_a", 64'(if_a.size_val), 64'h0);
    chk("idle_dbg_a", 64'(dbg_a), 64'h0);

    // 4: random sizes, unlimited run, then identical rerun from reset
    for (int i = 0; i < NRAND; i++) addr_tab[i] = 2'($urandom_range(0, NQ - 1));
    run_rand(1'b1);
    run_rand(1'b0);
    chk("rerun_all_used", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
